// File: rtl/picomips_io_ctrl.sv
// Board-side I/O controller for the picoMIPS core: synchronised, debounced poll switch,
// input word capture with valid/overrun handshake, and an LED output register.
module picomips_io_ctrl #(
    parameter int N               = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         poll_sw,
    input  logic [N-1:0] in_sw,
    input  logic         cpu_rd,
    input  logic         cpu_wr,
    input  logic [N-1:0] cpu_dout,
    output logic [N-1:0] cpu_din,
    output logic         in_valid,
    output logic         overrun,
    output logic [N-1:0] led
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, FULL, WAIT_REL} state_t;

    state_t               state;
    logic [SYNC_STAGES-1:0] poll_sync;
    logic [N-1:0]         in_sync [SYNC_STAGES];
    logic                 s_poll;
    logic [N-1:0]         s_in;
    logic [CW-1:0]        cnt;
    logic                 poll_stable;
    logic                 poll_prev;
    logic                 press;
    logic [N-1:0]         data;

    // Synchroniser chains: raw switches enter at index 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poll_sync <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) in_sync[i] <= '0;
        end else begin
            poll_sync  <= {poll_sync[SYNC_STAGES-2:0], poll_sw};
            in_sync[0] <= in_sw;
            for (int i = 1; i < SYNC_STAGES; i++) in_sync[i] <= in_sync[i-1];
        end
    end

    assign s_poll = poll_sync[SYNC_STAGES-1];
    assign s_in   = in_sync[SYNC_STAGES-1];

    // A change is accepted only after an unbroken run of mismatching samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            poll_stable <= 1'b0;
            poll_prev   <= 1'b0;
        end else begin
            poll_prev <= poll_stable;
            if (s_poll == poll_stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                poll_stable <= s_poll;
                cnt         <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = poll_stable & ~poll_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            data    <= '0;
            overrun <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (press) begin
                        data  <= s_in;
                        state <= FULL;
                    end
                end
                FULL: begin
                    // A press on an unread word is flagged, but a read still completes
                    if (press) overrun <= 1'b1;
                    if (cpu_rd) state <= WAIT_REL;
                end
                WAIT_REL: begin
                    if (!poll_stable) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led <= '0;
        end else if (cpu_wr) begin
            led <= cpu_dout;
        end
    end

    assign cpu_din  = data;
    assign in_valid = (state == FULL);

endmodule

// File: tb/tb_picomips_io_ctrl.sv
// Self-checking bench for picomips_io_ctrl: captured words are predicted into a
// scoreboard queue at press time and popped when in_valid rises.
module tb_picomips_io_ctrl;

    localparam int N = 8;
    localparam int SYNC_STAGES = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    // Input driven just after an edge; the next edge is e0, in_valid rises at e0+6
    localparam int LAT_TICKS = 1 + SYNC_STAGES + DEBOUNCE_CYCLES;

    logic         clk = 1'b0;
    logic         reset;
    logic         poll_sw;
    logic [N-1:0] in_sw;
    logic         cpu_rd;
    logic         cpu_wr;
    logic [N-1:0] cpu_dout;
    logic [N-1:0] cpu_din;
    logic         in_valid;
    logic         overrun;
    logic [N-1:0] led;

    int           n_checks = 0;
    int           n_fail = 0;
    logic [N-1:0] sb[$];

    picomips_io_ctrl #(
        .N(N), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .poll_sw(poll_sw), .in_sw(in_sw),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout),
        .cpu_din(cpu_din), .in_valid(in_valid), .overrun(overrun), .led(led)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max, output int edges);
        edges = 0;
        while (!in_valid && edges < max) begin
            tick();
            edges++;
        end
        if (!in_valid) edges = -1;
    endtask

    task automatic release_poll();
        poll_sw = 1'b0;
        repeat (LAT_TICKS + 3) tick();
    endtask

    task automatic press_and_capture(input logic [N-1:0] word, input string tag);
        int edges;
        logic [N-1:0] exp;
        in_sw   = word;
        poll_sw = 1'b1;
        sb.push_back(word);
        wait_valid(LAT_TICKS + 10, edges);
        n_checks++;
        if (edges !== LAT_TICKS) begin
            n_fail++;
            $display("FAIL %s_latency: in_valid after %0d ticks, expected %0d", tag, edges, LAT_TICKS);
        end
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s_data: scoreboard empty, got %h", tag, cpu_din);
        end else begin
            exp = sb.pop_front();
            if (cpu_din !== exp) begin
                n_fail++;
                $display("FAIL %s_data: cpu_din=%h expected %h", tag, cpu_din, exp);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; poll_sw = 1'b0; in_sw = '0;
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_dout = '0;
        repeat (3) tick();
        n_checks += 4;
        if (cpu_din !== 8'h00) begin n_fail++; $display("FAIL reset_din: %h expected 00", cpu_din); end
        if (in_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: %b expected 0", in_valid); end
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: %b expected 0", overrun); end
        if (led !== 8'h00) begin n_fail++; $display("FAIL reset_led: %h expected 00", led); end
        reset = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_capture();
        press_and_capture(8'h06, "capture");
    endtask

    task automatic test_handshake();
        bit seen;
        cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        n_checks++;
        if (in_valid !== 1'b0) begin n_fail++; $display("FAIL hs_rd_clear: in_valid=%b expected 0", in_valid); end
        in_sw = 8'h09;
        seen = 1'b0;
        repeat (LAT_TICKS + 5) begin tick(); if (in_valid) seen = 1'b1; end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL hs_no_capture: in_valid=1 expected 0 while held"); end
        release_poll();
        press_and_capture(8'h09, "hs_repress");
    endtask

    task automatic test_bounce();
        bit seen;
        cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        release_poll();
        in_sw = 8'h5A;
        seen = 1'b0;
        poll_sw = 1'b1; repeat (3) begin tick(); if (in_valid) seen = 1'b1; end
        poll_sw = 1'b0; repeat (1) begin tick(); if (in_valid) seen = 1'b1; end
        poll_sw = 1'b1; repeat (3) begin tick(); if (in_valid) seen = 1'b1; end
        poll_sw = 1'b0; repeat (LAT_TICKS + 3) begin tick(); if (in_valid) seen = 1'b1; end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL bounce_reject: in_valid=1 expected 0"); end
        press_and_capture(8'h5A, "bounce_hold");
    endtask

    task automatic test_overrun();
        release_poll();
        n_checks += 2;
        if (in_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_still_full: in_valid=%b expected 1", in_valid); end
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_pre: overrun=%b expected 0", overrun); end
        in_sw = 8'h33;
        poll_sw = 1'b1;
        repeat (LAT_TICKS + 3) tick();
        n_checks += 3;
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: overrun=%b expected 1", overrun); end
        if (cpu_din !== 8'h5A) begin n_fail++; $display("FAIL ovr_data: cpu_din=%h expected 5a", cpu_din); end
        if (in_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: in_valid=%b expected 1", in_valid); end
        cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        repeat (2) tick();
        n_checks += 2;
        if (in_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_rd_clear: in_valid=%b expected 0", in_valid); end
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: overrun=%b expected 1", overrun); end
    endtask

    task automatic test_led();
        release_poll();
        cpu_wr = 1'b1; cpu_dout = 8'hA5;
        tick();
        cpu_wr = 1'b0; cpu_dout = 8'h00;
        n_checks++;
        if (led !== 8'hA5) begin n_fail++; $display("FAIL led_write: led=%h expected a5", led); end
        repeat (3) tick();
        n_checks++;
        if (led !== 8'hA5) begin n_fail++; $display("FAIL led_hold: led=%h expected a5", led); end
        press_and_capture(8'hC3, "led_full");
        cpu_wr = 1'b1; cpu_dout = 8'h3C; cpu_rd = 1'b1;
        tick();
        cpu_wr = 1'b0; cpu_dout = 8'h00; cpu_rd = 1'b0;
        n_checks += 3;
        if (led !== 8'h3C) begin n_fail++; $display("FAIL led_coincident: led=%h expected 3c", led); end
        if (in_valid !== 1'b0) begin n_fail++; $display("FAIL rd_coincident: in_valid=%b expected 0", in_valid); end
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky2: overrun=%b expected 1", overrun); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        release_poll();
        press_and_capture(8'h77, "pre_reset");
        #3;
        reset = 1'b1;
        #1;
        n_checks += 4;
        if (cpu_din !== 8'h00) begin n_fail++; $display("FAIL rst_mid_din: %h expected 00", cpu_din); end
        if (in_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: %b expected 0", in_valid); end
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_mid_overrun: %b expected 0", overrun); end
        if (led !== 8'h00) begin n_fail++; $display("FAIL rst_mid_led: %h expected 00", led); end
        poll_sw = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        seen = 1'b0;
        repeat (LAT_TICKS + 3) begin tick(); if (in_valid) seen = 1'b1; end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL rst_discard: in_valid=1 after reset expected 0"); end
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain: %0d words left expected 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_handshake();
        test_bounce();
        test_overrun();
        test_led();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
